// File: rtl/vx_smem_bank.sv
// vx_smem_bank
// Single-ported shared-memory bank terminating one output port of the
// shared-memory request switch. Accepts byte-enabled read/write requests,
// performs them against a local SRAM with one-cycle read latency, and returns
// tagged read responses in order through a credit-protected response queue.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   req_valid/ready: request handshake (ready depends on register state only)
//   req_rw         : 1 = write, 0 = read
//   req_addr       : word address
//   req_byteen     : write byte enables (ignored for reads)
//   req_data       : write data
//   req_tag        : opaque request tag, returned with the read response
//   rsp_valid/ready: response handshake
//   rsp_data/tag   : read data and originating tag
module vx_smem_bank #(
    parameter  int DATA_SIZE      = 4,
    parameter  int NUM_WORDS      = 1024,
    parameter  int TAG_WIDTH      = 8,
    parameter  int RSP_QUEUE_SIZE = 2,
    localparam int DATA_WIDTH     = 8 * DATA_SIZE,
    localparam int ADDR_WIDTH     = $clog2(NUM_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_rw,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_SIZE-1:0]  req_byteen,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    input  logic                  rsp_ready
);

    localparam int QW = (RSP_QUEUE_SIZE > 1) ? $clog2(RSP_QUEUE_SIZE) : 1;
    localparam int CW = $clog2(RSP_QUEUE_SIZE + 1);

    // Queue pointer advance with wrap for non-power-of-2 depths.
    function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
        if (p == QW'(RSP_QUEUE_SIZE - 1)) begin
            return {QW{1'b0}};
        end else begin
            return p + QW'(1);
        end
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

    logic                  req_ready_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic [TAG_WIDTH-1:0]  s1_tag_q;

    logic [DATA_WIDTH-1:0] q_data_q [RSP_QUEUE_SIZE];
    logic [TAG_WIDTH-1:0]  q_tag_q  [RSP_QUEUE_SIZE];
    logic [QW-1:0]         wptr_q, wptr_d;
    logic [QW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         qcnt_q, qcnt_d;

    logic req_fire_s, rd_acc_s, wr_acc_s;
    logic q_empty_s, push_s, pop_s, rsp_fire_s;

    // Request acceptance; reset blocks any access in the reset cycle.
    assign req_fire_s = req_valid && req_ready_q && !reset;
    assign rd_acc_s   = req_fire_s && !req_rw;
    assign wr_acc_s   = req_fire_s && req_rw;
    assign req_ready  = req_ready_q;

    assign q_empty_s  = (qcnt_q == {CW{1'b0}});
    assign rsp_fire_s = rsp_valid && rsp_ready;
    // s1 leaves through the bypass only when the queue is empty and the
    // consumer takes it; in every other case it must be queued.
    assign push_s     = s1_valid_q && (!q_empty_s || !rsp_ready);
    assign pop_s      = !q_empty_s && rsp_ready;

    // Response mux: queue head has priority over the bypassed s1 entry.
    always_comb begin
        rsp_valid = 1'b0;
        rsp_data  = s1_data_q;
        rsp_tag   = s1_tag_q;
        if (!q_empty_s) begin
            rsp_valid = 1'b1;
            rsp_data  = q_data_q[rptr_q];
            rsp_tag   = q_tag_q[rptr_q];
        end else begin
            rsp_valid = s1_valid_q;
        end
    end

    // Next-state for credit counter and queue bookkeeping.
    always_comb begin
        cnt_d  = cnt_q;
        qcnt_d = qcnt_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        case ({rd_acc_s, rsp_fire_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        case ({push_s, pop_s})
            2'b10:   qcnt_d = qcnt_q + CW'(1);
            2'b01:   qcnt_d = qcnt_q - CW'(1);
            default: qcnt_d = qcnt_q;
        endcase
        if (push_s) begin
            wptr_d = ptr_inc(wptr_q);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = ptr_inc(rptr_q);
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Control state registers; ready is precomputed from the next credit count.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready_q <= 1'b1;
            cnt_q       <= {CW{1'b0}};
            s1_valid_q  <= 1'b0;
            qcnt_q      <= {CW{1'b0}};
            wptr_q      <= {QW{1'b0}};
            rptr_q      <= {QW{1'b0}};
        end else begin
            req_ready_q <= (cnt_d != CW'(RSP_QUEUE_SIZE));
            cnt_q       <= cnt_d;
            s1_valid_q  <= rd_acc_s;
            qcnt_q      <= qcnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
        end
    end

    // SRAM port: byte-enabled write or registered read into s1 (not reset).
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            for (int i = 0; i < DATA_SIZE; i++) begin
                if (req_byteen[i]) begin
                    mem_q[req_addr][8*i +: 8] <= req_data[8*i +: 8];
                end
            end
        end
        if (rd_acc_s) begin
            s1_data_q <= mem_q[req_addr];
            s1_tag_q  <= req_tag;
        end
    end

    // Response queue storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_data_q[wptr_q] <= s1_data_q;
            q_tag_q[wptr_q]  <= s1_tag_q;
        end
    end

endmodule

// File: tb/tb_vx_smem_bank.sv
// Scoreboard bench for vx_smem_bank: stimulus pushes expected read responses,
// a negedge monitor pops and compares on every response fire.
module tb_vx_smem_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_rw = 1'b0;
    logic [9:0]  req_addr = 10'd0;
    logic [3:0]  req_byteen = 4'h0;
    logic [31:0] req_data = 32'h0;
    logic [7:0]  req_tag = 8'h0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_tag;
    logic        rsp_ready = 1'b1;

    int n_checks = 0;
    int n_fail = 0;

    logic [39:0] sb[$];
    logic [31:0] model [32];

    bit          prev_stall = 1'b0;
    logic [39:0] prev_rsp;

    vx_smem_bank dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_rw     (req_rw),
        .req_addr   (req_addr),
        .req_byteen (req_byteen),
        .req_data   (req_data),
        .req_tag    (req_tag),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_ready  (rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // Monitor: compare every fired response against the scoreboard head.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {63'd0, rsp_valid}, 64'd1);
                chk("stall_stable", {24'd0, rsp_tag, rsp_data}, {24'd0, prev_rsp});
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got tag %0h data %0h expected no response",
                             rsp_tag, rsp_data);
                end else begin
                    logic [39:0] e;
                    e = sb.pop_front();
                    chk("rsp_tag", {56'd0, rsp_tag}, {56'd0, e[39:32]});
                    chk("rsp_data", {32'd0, rsp_data}, {32'd0, e[31:0]});
                end
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_rsp   = {rsp_tag, rsp_data};
        end
    end

    // Issue one request and hold it until accepted (bounded). Reads push exp.
    task automatic send(input logic rw, input int addr, input logic [3:0] be,
                        input logic [31:0] d, input logic [7:0] tag,
                        input logic [31:0] exp);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1; req_rw = rw; req_addr = 10'(addr);
        req_byteen = be; req_data = d; req_tag = tag;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
        end else begin
            if (rw) model[addr] = merge(model[addr], d, be);
            else    sb.push_back({tag, exp});
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int accepts;
        bit acc;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_req_ready", {63'd0, req_ready}, 64'd1);

        // Byte-enable merge and one-cycle latency.
        send(1'b1, 20, 4'hF, 32'hAABBCCDD, 8'h01, 32'h0);
        send(1'b1, 20, 4'b0101, 32'h11223344, 8'h01, 32'h0);
        send(1'b0, 20, 4'h0, 32'h0, 8'h7E, 32'hAA22CC44);
        chk("lat_valid", {63'd0, rsp_valid}, 64'd1);
        chk("lat_data", {32'd0, rsp_data}, 64'hAA22CC44);
        @(posedge clk); #1;
        chk("lat_valid_gone", {63'd0, rsp_valid}, 64'd0);

        // Streaming: preload addr*3, then 16 back-to-back reads.
        for (int a = 0; a < 16; a++) send(1'b1, a, 4'hF, 32'(a * 3), 8'h00, 32'h0);
        for (int a = 0; a < 16; a++) begin
            chk("stream_ready", {63'd0, req_ready}, 64'd1);
            send(1'b0, a, 4'h0, 32'h0, 8'(a), 32'(a * 3));
            chk("stream_valid", {63'd0, rsp_valid}, 64'd1);
        end
        drain();

        // Backpressure / credit exhaustion.
        rsp_ready = 1'b0;
        accepts = 0;
        req_valid = 1'b1; req_rw = 1'b0;
        for (int c = 0; c < 6; c++) begin
            req_addr = 10'(accepts); req_tag = 8'h40 + 8'(accepts);
            if (req_ready) begin
                sb.push_back({req_tag, model[accepts]});
                accepts++;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("bp_accepts", 64'(accepts), 64'd2);
        chk("bp_full_ready", {63'd0, req_ready}, 64'd0);

        // Write presented while credits are exhausted must not land.
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 10'd20;
        req_byteen = 4'hF; req_data = 32'h0;
        repeat (3) begin
            chk("stall_wr_ready", {63'd0, req_ready}, 64'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("bp_ready_before_fire", {63'd0, req_ready}, 64'd0);
        @(posedge clk); #1;
        chk("bp_ready_after_fire", {63'd0, req_ready}, 64'd1);
        drain();
        send(1'b0, 20, 4'h0, 32'h0, 8'h55, 32'hAA22CC44);
        drain();

        // Random rsp_ready and read/write mix against the model.
        acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            if (acc || !req_valid) begin
                req_valid = 1'b1;
                req_rw = 1'($urandom_range(0, 1));
                req_addr = 10'($urandom_range(0, 15));
                req_byteen = 4'($urandom_range(0, 15));
                req_data = $urandom;
                req_tag = 8'($urandom_range(0, 255));
            end
            acc = req_ready;
            if (acc) begin
                if (req_rw) model[req_addr] = merge(model[req_addr], req_data, req_byteen);
                else        sb.push_back({req_tag, model[req_addr]});
            end
            @(posedge clk); #1;
            chk("outstanding_max", {63'd0, sb.size() <= 2}, 64'd1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // Reset with two reads pending.
        rsp_ready = 1'b0;
        send(1'b0, 0, 4'h0, 32'h0, 8'hA0, model[0]);
        send(1'b0, 1, 4'h0, 32'h0, 8'hA1, model[1]);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mid_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_mid_ready", {63'd0, req_ready}, 64'd1);
        rsp_ready = 1'b1;
        send(1'b0, 20, 4'h0, 32'h0, 8'h33, 32'hAA22CC44);
        drain();
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
